// File: rtl/wm8731_cfg_pkg.sv
// Shared types and constants for the WM8731 configuration sequencer:
// FSM states, codec register addresses and the default init table.
package wm8731_cfg_pkg;

    localparam int unsigned WORD_W           = 16;
    localparam int unsigned INDEX_W          = 4;
    localparam int unsigned NUM_REGS_DEFAULT = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_T,
        ST_LOAD_R,
        ST_ISSUE,
        ST_WAIT_FIN,
        ST_GAP
    } cfg_state_e;

    localparam logic [6:0] R0_LLINE_IN   = 7'h00;
    localparam logic [6:0] R1_RLINE_IN   = 7'h01;
    localparam logic [6:0] R2_LHP_OUT    = 7'h02;
    localparam logic [6:0] R3_RHP_OUT    = 7'h03;
    localparam logic [6:0] R4_ANALOG     = 7'h04;
    localparam logic [6:0] R5_DIGITAL    = 7'h05;
    localparam logic [6:0] R6_POWER      = 7'h06;
    localparam logic [6:0] R7_IFACE      = 7'h07;
    localparam logic [6:0] R8_SAMPLING   = 7'h08;
    localparam logic [6:0] R9_ACTIVE     = 7'h09;
    localparam logic [6:0] R15_RESET     = 7'h0F;

    // Each word is {register address[6:0], data[8:0]}
    localparam logic [WORD_W-1:0] CFG_W0  = {R15_RESET,   9'h000};
    localparam logic [WORD_W-1:0] CFG_W1  = {R6_POWER,    9'h000};
    localparam logic [WORD_W-1:0] CFG_W2  = {R0_LLINE_IN, 9'h017};
    localparam logic [WORD_W-1:0] CFG_W3  = {R1_RLINE_IN, 9'h017};
    localparam logic [WORD_W-1:0] CFG_W4  = {R2_LHP_OUT,  9'h079};
    localparam logic [WORD_W-1:0] CFG_W5  = {R3_RHP_OUT,  9'h079};
    localparam logic [WORD_W-1:0] CFG_W6  = {R4_ANALOG,   9'h012};
    localparam logic [WORD_W-1:0] CFG_W7  = {R5_DIGITAL,  9'h000};
    localparam logic [WORD_W-1:0] CFG_W8  = {R7_IFACE,    9'h042};
    localparam logic [WORD_W-1:0] CFG_W9  = {R8_SAMPLING, 9'h000};
    localparam logic [WORD_W-1:0] CFG_W10 = {R9_ACTIVE,   9'h001};

endpackage

// File: rtl/wm8731_config_sequencer_if.sv
// Runtime write request channel and IIC writer handshake, grouped as one bundle.
interface wm8731_config_sequencer_if;
    import wm8731_cfg_pkg::*;

    logic              WR_REQ;
    logic [WORD_W-1:0] WR_DATA;
    logic              WR_ACK;
    logic              IIC_ENABLE;
    logic [WORD_W-1:0] IIC_DATA;
    logic              IIC_FINISHED;

    modport master (
        input  WR_REQ, WR_DATA, IIC_FINISHED,
        output WR_ACK, IIC_ENABLE, IIC_DATA
    );

    modport slave (
        output WR_REQ, WR_DATA, IIC_FINISHED,
        input  WR_ACK, IIC_ENABLE, IIC_DATA
    );
endinterface

// File: rtl/wm8731_cfg_rom.sv
// Combinational lookup of the default WM8731 init table.
module wm8731_cfg_rom
    import wm8731_cfg_pkg::*;
(
    input  logic [INDEX_W-1:0] index,
    output logic [WORD_W-1:0]  word
);

    always_comb begin
        word = '0;
        case (index)
            4'd0:    word = CFG_W0;
            4'd1:    word = CFG_W1;
            4'd2:    word = CFG_W2;
            4'd3:    word = CFG_W3;
            4'd4:    word = CFG_W4;
            4'd5:    word = CFG_W5;
            4'd6:    word = CFG_W6;
            4'd7:    word = CFG_W7;
            4'd8:    word = CFG_W8;
            4'd9:    word = CFG_W9;
            4'd10:   word = CFG_W10;
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/wm8731_config_sequencer.sv
// Drives the IIC writer through the WM8731 init table, then serves runtime
// single-word writes; each transfer is bounded by a FINISHED timeout.
module wm8731_config_sequencer
    import wm8731_cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS       = NUM_REGS_DEFAULT,
    parameter int unsigned GAP_CYCLES     = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65536
)(
    input  logic                 MCLK,
    input  logic                 RESET,
    input  logic                 START,
    wm8731_config_sequencer_if.master bus,
    output logic                 BUSY,
    output logic                 CFG_DONE,
    output logic                 CFG_ERR,
    output logic [INDEX_W-1:0]   CFG_INDEX
);

    localparam int unsigned CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    cfg_state_e         state_q, state_n;
    logic               enable_q, enable_n;
    logic [WORD_W-1:0]  data_q, data_n;
    logic               ack_q, ack_n;
    logic               busy_q;
    logic               done_q, done_n;
    logic               err_q, err_n;
    logic [INDEX_W-1:0] index_q, index_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               src_r_q, src_r_n;
    logic               abort_q, abort_n;
    logic               fin_q;
    logic               fin_rise;
    logic [WORD_W-1:0]  rom_word;

    wm8731_cfg_rom u_rom (
        .index (index_q),
        .word  (rom_word)
    );

    assign fin_rise = bus.IIC_FINISHED & ~fin_q;

    // State and output registers
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
            data_q   <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            index_q  <= '0;
            cnt_q    <= '0;
            src_r_q  <= 1'b0;
            abort_q  <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            enable_q <= enable_n;
            data_q   <= data_n;
            ack_q    <= ack_n;
            busy_q   <= (state_n != ST_IDLE);
            done_q   <= done_n;
            err_q    <= err_n;
            index_q  <= index_n;
            cnt_q    <= cnt_n;
            src_r_q  <= src_r_n;
            abort_q  <= abort_n;
            fin_q    <= bus.IIC_FINISHED;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state_q;
        enable_n = enable_q;
        data_n   = data_q;
        ack_n    = 1'b0;
        done_n   = done_q;
        err_n    = err_q;
        index_n  = index_q;
        cnt_n    = cnt_q;
        src_r_n  = src_r_q;
        abort_n  = abort_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    index_n = '0;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                    state_n = ST_LOAD_T;
                // Skip the ACK cycle so a requester still holding WR_REQ is not served twice
                end else if (bus.WR_REQ && done_q && !ack_q) begin
                    state_n = ST_LOAD_R;
                end
            end
            ST_LOAD_T: begin
                data_n  = rom_word;
                src_r_n = 1'b0;
                abort_n = 1'b0;
                state_n = ST_ISSUE;
            end
            ST_LOAD_R: begin
                data_n  = bus.WR_DATA;
                src_r_n = 1'b1;
                abort_n = 1'b0;
                state_n = ST_ISSUE;
            end
            ST_ISSUE: begin
                enable_n = 1'b1;
                cnt_n    = '0;
                state_n  = ST_WAIT_FIN;
            end
            ST_WAIT_FIN: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (fin_rise) begin
                    enable_n = 1'b0;
                    cnt_n    = '0;
                    state_n  = ST_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    enable_n = 1'b0;
                    err_n    = 1'b1;
                    abort_n  = 1'b1;
                    cnt_n    = '0;
                    state_n  = ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_n = '0;
                    if (abort_q) begin
                        state_n = ST_IDLE;
                    end else if (src_r_q) begin
                        ack_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else if (index_q == INDEX_W'(NUM_REGS - 1)) begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        index_n = index_q + INDEX_W'(1);
                        state_n = ST_LOAD_T;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.IIC_ENABLE = enable_q;
    assign bus.IIC_DATA   = data_q;
    assign bus.WR_ACK     = ack_q;
    assign BUSY           = busy_q;
    assign CFG_DONE       = done_q;
    assign CFG_ERR        = err_q;
    assign CFG_INDEX      = index_q;

endmodule

// File: tb/tb_wm8731_config_sequencer.sv
// Directed bench for wm8731_config_sequencer with a behavioural IIC writer
// model; timing parameters are scaled down to keep runs short.
module tb_wm8731_config_sequencer;

    localparam int unsigned NREGS     = 11;
    localparam int unsigned GAP       = 16;
    localparam int unsigned TOUT      = 256;
    localparam int unsigned FIN_DELAY = 64;
    localparam int unsigned FIN_HOLD  = 8;

    logic       mclk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       cfg_done;
    logic       cfg_err;
    logic [3:0] cfg_index;

    wm8731_config_sequencer_if bus ();

    wm8731_config_sequencer #(
        .NUM_REGS       (NREGS),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .MCLK      (mclk),
        .RESET     (reset),
        .START     (start),
        .bus       (bus),
        .BUSY      (busy),
        .CFG_DONE  (cfg_done),
        .CFG_ERR   (cfg_err),
        .CFG_INDEX (cfg_index)
    );

    always #5 mclk = ~mclk;

    logic [15:0] exp_tbl [11] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                  16'h0812, 16'h0A00, 16'h0E42, 16'h1000, 16'h1201};

    // Writer model: FINISHED rises FIN_DELAY cycles after ENABLE rises, holds FIN_HOLD cycles
    logic writer_alive = 1'b1;
    logic wen_q = 1'b0;
    logic fin = 1'b0;
    int   wcnt = 0;

    always @(posedge mclk) begin
        wen_q <= bus.IIC_ENABLE;
        if (bus.IIC_ENABLE && !wen_q) begin
            wcnt <= 1;
            fin  <= 1'b0;
        end else if (wcnt != 0) begin
            wcnt <= wcnt + 1;
            if (wcnt == int'(FIN_DELAY) && writer_alive) fin <= 1'b1;
            if (wcnt == int'(FIN_DELAY + FIN_HOLD)) begin
                fin  <= 1'b0;
                wcnt <= 0;
            end
        end
    end

    assign bus.IIC_FINISHED = fin;

    // Monitor: log each transfer word, the low time before it, and WR_ACK pulses
    logic [15:0] xfer_q [$];
    int          gap_q  [$];
    logic        mon_en_q  = 1'b0;
    logic        mon_ack_q = 1'b0;
    int          low_run   = 0;
    int          ack_cnt   = 0;
    logic        ack_wide  = 1'b0;

    always @(negedge mclk) begin
        if (bus.IIC_ENABLE && !mon_en_q) begin
            xfer_q.push_back(bus.IIC_DATA);
            gap_q.push_back(low_run);
        end
        low_run   <= bus.IIC_ENABLE ? 0 : low_run + 1;
        mon_en_q  <= bus.IIC_ENABLE;
        if (bus.WR_ACK && !mon_ack_q) ack_cnt <= ack_cnt + 1;
        if (bus.WR_ACK && mon_ack_q) ack_wide <= 1'b1;
        mon_ack_q <= bus.WR_ACK;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_ack(input int budget, input string tag);
        int n = 0;
        while (!bus.WR_ACK && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(bus.WR_ACK), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_index_en(input logic [3:0] idx, input int budget, input string tag);
        int n = 0;
        while (!(bus.IIC_ENABLE && cfg_index == idx) && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(bus.IIC_ENABLE && cfg_index == idx), 32'd1);
    endtask

    task automatic chk_min_gap(input int first, input int last, input string tag);
        int mn = 32'h7FFF_FFFF;
        for (int i = first; i <= last; i++) if (gap_q[i] < mn) mn = gap_q[i];
        chk(tag, 32'(mn >= int'(GAP)), 32'd1);
    endtask

    initial begin
        int base;
        int ack_base;
        int n;

        reset       = 1'b1;
        start       = 1'b0;
        bus.WR_REQ  = 1'b0;
        bus.WR_DATA = 16'h0000;
        tick(3);

        // Reset state
        chk("rst_enable", 32'(bus.IIC_ENABLE), 32'd0);
        chk("rst_data",   32'(bus.IIC_DATA),   32'd0);
        chk("rst_ack",    32'(bus.WR_ACK),     32'd0);
        chk("rst_busy",   32'(busy),           32'd0);
        chk("rst_done",   32'(cfg_done),       32'd0);
        chk("rst_err",    32'(cfg_err),        32'd0);
        chk("rst_index",  32'(cfg_index),      32'd0);
        reset = 1'b0;
        tick(2);

        // Runtime request before init is held off
        bus.WR_DATA = 16'h0479;
        bus.WR_REQ  = 1'b1;
        tick(40);
        chk("early_req_xfers", 32'(xfer_q.size()), 32'd0);
        chk("early_req_ack",   32'(ack_cnt),       32'd0);
        chk("early_req_busy",  32'(busy),          32'd0);

        // Init run with the request still pending; START sampled at the next edge
        pulse_start();
        chk("lat_edge1_en", 32'(bus.IIC_ENABLE), 32'd0);
        tick(1);
        chk("lat_edge2_en", 32'(bus.IIC_ENABLE), 32'd0);
        tick(1);
        chk("lat_edge3_en",   32'(bus.IIC_ENABLE), 32'd1);
        chk("lat_edge3_data", 32'(bus.IIC_DATA),   32'h1E00);
        chk("lat_edge3_busy", 32'(busy),           32'd1);
        wait_ack(6000, "init_then_req_ack");
        bus.WR_REQ = 1'b0;
        chk("init_done",    32'(cfg_done),  32'd1);
        chk("init_err",     32'(cfg_err),   32'd0);
        chk("init_index",   32'(cfg_index), 32'd10);
        chk("ack_busy",     32'(busy),      32'd0);
        chk("init_nxfers",  32'(xfer_q.size()), 32'd12);
        for (int i = 0; i < 11; i++) chk($sformatf("init_word%0d", i), 32'(xfer_q[i]), 32'(exp_tbl[i]));
        chk("req_word", 32'(xfer_q[11]), 32'h0479);
        chk_min_gap(1, 11, "init_min_gap");
        tick(30);
        chk("req_ack_count", 32'(ack_cnt),       32'd1);
        chk("req_no_extra",  32'(xfer_q.size()), 32'd12);

        // START and WR_REQ in the same idle cycle: table first, then the request
        base     = xfer_q.size();
        ack_base = ack_cnt;
        bus.WR_DATA = 16'h0C5A;
        bus.WR_REQ  = 1'b1;
        pulse_start();
        chk("both_done_cleared", 32'(cfg_done), 32'd0);
        chk("both_busy",         32'(busy),     32'd1);
        wait_ack(6000, "both_ack");
        bus.WR_REQ = 1'b0;
        chk("both_done",   32'(cfg_done),           32'd1);
        chk("both_nxfers", 32'(xfer_q.size() - base), 32'd12);
        chk("both_first",  32'(xfer_q[base]),       32'h1E00);
        chk("both_last_t", 32'(xfer_q[base + 10]),  32'h1201);
        chk("both_req",    32'(xfer_q[base + 11]),  32'h0C5A);
        tick(10);
        chk("both_ack_count", 32'(ack_cnt - ack_base), 32'd1);

        // Writer never finishes: timeout aborts the run
        writer_alive = 1'b0;
        base = xfer_q.size();
        pulse_start();
        n = 0;
        while (!bus.IIC_ENABLE && n < 10) begin tick(1); n++; end
        chk("to_enable_rise", 32'(bus.IIC_ENABLE), 32'd1);
        n = 0;
        while (bus.IIC_ENABLE && n < 400) begin tick(1); n++; end
        chk("to_enable_cycles", 32'(n),       32'(TOUT));
        chk("to_err_set",       32'(cfg_err), 32'd1);
        n = 0;
        while (busy && n < 100) begin tick(1); n++; end
        chk("to_gap_cycles", 32'(n),         32'(GAP));
        chk("to_err",        32'(cfg_err),   32'd1);
        chk("to_done",       32'(cfg_done),  32'd0);
        chk("to_index",      32'(cfg_index), 32'd0);
        tick(50);
        chk("to_nxfers", 32'(xfer_q.size() - base), 32'd1);
        chk("to_idle",   32'(busy),                 32'd0);
        writer_alive = 1'b1;

        // Reset in the middle of the index 5 transfer
        pulse_start();
        wait_index_en(4'd5, 3000, "rst5_reach");
        reset = 1'b1;
        tick(1);
        chk("rst5_enable", 32'(bus.IIC_ENABLE), 32'd0);
        chk("rst5_index",  32'(cfg_index),      32'd0);
        chk("rst5_busy",   32'(busy),           32'd0);
        chk("rst5_err",    32'(cfg_err),        32'd0);
        reset = 1'b0;
        base = xfer_q.size();
        tick(300);
        chk("rst5_quiet", 32'(xfer_q.size() - base), 32'd0);
        chk("rst5_idle",  32'(busy),                 32'd0);

        // START during the sequence is ignored
        base = xfer_q.size();
        pulse_start();
        wait_index_en(4'd3, 3000, "mid_reach");
        pulse_start();
        chk("mid_busy", 32'(busy), 32'd1);
        wait_idle(6000, "mid_idle");
        chk("mid_nxfers", 32'(xfer_q.size() - base), 32'd11);
        chk("mid_word3",  32'(xfer_q[base + 3]),     32'h0217);
        chk("mid_word10", 32'(xfer_q[base + 10]),    32'h1201);
        chk("mid_done",   32'(cfg_done),             32'd1);
        chk("mid_err",    32'(cfg_err),              32'd0);
        chk("mid_index",  32'(cfg_index),            32'd10);
        chk_min_gap(base + 1, base + 10, "mid_min_gap");

        chk("ack_single_cycle", 32'(ack_wide), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
